// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings for the multicycle sequencing controller
package cpu_ctrl_pkg;
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;
  localparam logic [1:0] PC_ALU = 2'd0, PC_BR = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3;
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_R31 = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MDR = 2'd1, WB_PC = 2'd2;
  localparam logic [1:0] A_PC = 2'd0, A_RS = 2'd1, A_SHAMT = 2'd2;
  localparam logic [1:0] B_RT = 2'd0, B_4 = 2'd1, B_IMM = 2'd2, B_IMM2 = 2'd3;
  localparam int C_NOP = 0, C_RTYPE = 1, C_ITYPE = 2, C_LW = 3, C_SW = 4, C_BEQ = 5;
  localparam int C_BNE = 6, C_J = 7, C_JR = 8, C_JAL = 9, C_JALR = 10, C_SHIFT = 11;
  localparam int C_N = 12;
  typedef logic [C_N-1:0] cls_t;
  // Reduce the decoder flags to a single one-hot class (all zero when undecodable)
  function automatic cls_t pick_class(input cls_t f);
    cls_t c;
    c = '0;
    if (f[C_NOP]) c[C_NOP] = 1'b1;
    else if (f[C_JR]) c[C_JR] = 1'b1;
    else if (f[C_JALR]) c[C_JALR] = 1'b1;
    else if (f[C_SHIFT]) c[C_SHIFT] = 1'b1;
    else if (f[C_RTYPE]) c[C_RTYPE] = 1'b1;
    else if (f[C_ITYPE]) c[C_ITYPE] = 1'b1;
    else if (f[C_LW]) c[C_LW] = 1'b1;
    else if (f[C_SW]) c[C_SW] = 1'b1;
    else if (f[C_BEQ]) c[C_BEQ] = 1'b1;
    else if (f[C_BNE]) c[C_BNE] = 1'b1;
    else if (f[C_J]) c[C_J] = 1'b1;
    else if (f[C_JAL]) c[C_JAL] = 1'b1;
    return c;
  endfunction
endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// multicycle_ctrl_outdec: combinational map from state/class/flags to datapath strobes
import cpu_ctrl_pkg::*;
module multicycle_ctrl_outdec (
  input  state_t     state,
  input  cls_t       cls,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       illegal,
  output logic       retire
);
  // Per-state strobe decode; everything not driven in a state stays 0
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_ALU;
    reg_we    = 1'b0;
    reg_dst   = RD_RT;
    wb_sel    = WB_ALU;
    alu_src_a = A_PC;
    alu_src_b = B_RT;
    illegal   = 1'b0;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = B_4;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = B_IMM2;
        illegal   = cls == '0;
        retire    = cls[C_NOP] | cls[C_J] | cls[C_JAL] | cls[C_JR] | cls[C_JALR];
        pc_we     = cls[C_J] | cls[C_JAL] | cls[C_JR] | cls[C_JALR];
        pc_src    = (cls[C_JR] | cls[C_JALR]) ? PC_RS : (cls[C_J] | cls[C_JAL]) ? PC_JUMP : PC_ALU;
        reg_we    = cls[C_JAL] | cls[C_JALR];
        reg_dst   = cls[C_JAL] ? RD_R31 : cls[C_JALR] ? RD_RD : RD_RT;
        wb_sel    = (cls[C_JAL] | cls[C_JALR]) ? WB_PC : WB_ALU;
      end
      S_EXEC: begin
        alu_src_a = cls[C_SHIFT] ? A_SHAMT : A_RS;
        alu_src_b = (cls[C_ITYPE] | cls[C_LW] | cls[C_SW]) ? B_IMM : B_RT;
        pc_we     = (cls[C_BEQ] & alu_zero) | (cls[C_BNE] & ~alu_zero);
        pc_src    = (cls[C_BEQ] | cls[C_BNE]) ? PC_BR : PC_ALU;
        retire    = cls[C_BEQ] | cls[C_BNE];
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = cls[C_SW];
        retire  = cls[C_SW] & mem_ready;
      end
      S_WB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        reg_dst = (cls[C_ITYPE] | cls[C_LW]) ? RD_RT : RD_RD;
        wb_sel  = cls[C_LW] ? WB_MDR : WB_ALU;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with retired-instruction counter
import cpu_ctrl_pkg::*;
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             nop,
  input  logic             rtype_alu,
  input  logic             itype_alu,
  input  logic             lw,
  input  logic             sw,
  input  logic             beq,
  input  logic             bne,
  input  logic             j,
  input  logic             jr,
  input  logic             jal,
  input  logic             jalr,
  input  logic             shift,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);
  state_t cur, nxt;
  cls_t   raw, pri, cls_q, cls;
  logic   retire;
  assign raw[C_NOP]   = nop;
  assign raw[C_RTYPE] = rtype_alu;
  assign raw[C_ITYPE] = itype_alu;
  assign raw[C_LW]    = lw;
  assign raw[C_SW]    = sw;
  assign raw[C_BEQ]   = beq;
  assign raw[C_BNE]   = bne;
  assign raw[C_J]     = j;
  assign raw[C_JR]    = jr;
  assign raw[C_JAL]   = jal;
  assign raw[C_JALR]  = jalr;
  assign raw[C_SHIFT] = shift;
  assign pri   = pick_class(raw);
  assign cls   = (cur == S_DECODE) ? pri : cls_q;
  assign state = cur;
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_RESET;
    else cur <= nxt;
  end
  // Next-state sequencing; short classes return to FETCH straight from DECODE
  always_comb begin
    nxt = S_RESET;
    case (cur)
      S_RESET:  nxt = S_FETCH;
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: nxt = (pri == '0 || pri[C_NOP] || pri[C_J] || pri[C_JAL] || pri[C_JR] || pri[C_JALR]) ? S_FETCH : S_EXEC;
      S_EXEC:   nxt = (cls_q[C_BEQ] | cls_q[C_BNE]) ? S_FETCH : (cls_q[C_LW] | cls_q[C_SW]) ? S_MEM : S_WB;
      S_MEM:    nxt = !mem_ready ? S_MEM : cls_q[C_LW] ? S_WB : S_FETCH;
      S_WB:     nxt = S_FETCH;
      default:  nxt = S_RESET;
    endcase
  end
  // Class register captures the prioritised decode and the retire counter advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q   <= '0;
      instret <= '0;
    end else begin
      if (cur == S_DECODE) cls_q <= pri;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end
  multicycle_ctrl_outdec u_outdec (
    .state     (cur),
    .cls       (cls),
    .alu_zero  (alu_zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .iord      (iord),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .reg_we    (reg_we),
    .reg_dst   (reg_dst),
    .wb_sel    (wb_sel),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .illegal   (illegal),
    .retire    (retire)
  );
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed checks of sequencing, strobes, cycle counts and counter wrap
module tb_multicycle_ctrl;
  localparam int CW = 4;
  localparam logic [11:0] F_NOP = 12'h001, F_RT = 12'h002, F_IT = 12'h004, F_LW = 12'h008;
  localparam logic [11:0] F_SW = 12'h010, F_BEQ = 12'h020, F_BNE = 12'h040, F_J = 12'h080;
  localparam logic [11:0] F_JR = 12'h100, F_JAL = 12'h200, F_JALR = 12'h400, F_SH = 12'h800;
  logic clk = 1'b0, rst_n = 1'b0, alu_zero = 1'b0, mem_ready = 1'b1;
  logic [11:0] flags = '0;
  logic mem_req, mem_we, iord, ir_we, pc_we, reg_we, illegal;
  logic [1:0] pc_src, reg_dst, wb_sel, alu_src_a, alu_src_b;
  logic [CW-1:0] instret;
  logic [2:0] state;
  logic [16:0] o, dec_v, exe_v, mem_v, wb_v;
  int checks = 0, errors = 0, cyc, ilc;
  always #5 clk = ~clk;
  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .nop(flags[0]), .rtype_alu(flags[1]), .itype_alu(flags[2]), .lw(flags[3]),
    .sw(flags[4]), .beq(flags[5]), .bne(flags[6]), .j(flags[7]),
    .jr(flags[8]), .jal(flags[9]), .jalr(flags[10]), .shift(flags[11]),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .illegal(illegal),
    .instret(instret), .state(state)
  );
  assign o = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst, wb_sel, alu_src_a, alu_src_b, illegal};
  function automatic logic [16:0] ev(input logic rq, we, io, irw, pcw, input logic [1:0] ps,
                                     input logic rw, input logic [1:0] rd, ws, sa, sb, input logic il);
    return {rq, we, io, irw, pcw, ps, rw, rd, ws, sa, sb, il};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // One instruction from FETCH back to FETCH, snapshotting strobes in each state
  task automatic run(input logic [11:0] f, input int fw, input int mw, input logic z);
    int fc, mc;
    logic left;
    fc = 0; mc = 0; cyc = 0; ilc = 0; left = 1'b0;
    flags = f; alu_zero = z;
    dec_v = '1; exe_v = '1; mem_v = '1; wb_v = '1;
    do begin
      if (state >= 3) flags = '0;
      mem_ready = (state == 1) ? (fc >= fw) : (state == 4) ? (mc >= mw) : 1'b1;
      #1;
      case (state)
        3'd2: dec_v = o;
        3'd3: exe_v = o;
        3'd4: mem_v = o;
        3'd5: wb_v = o;
        default: ;
      endcase
      ilc += int'(illegal);
      if (state == 1) fc++;
      if (state == 4) mc++;
      @(negedge clk);
      cyc++;
      if (state != 1) left = 1'b1;
    end while (!(left && state == 1) && cyc < 40);
    mem_ready = 1'b1;
  endtask
  initial begin
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_instret", 32'(instret), 0);
    check("rst_outs", 32'(o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("fetch_state", 32'(state), 1);
    check("fetch_outs", 32'(o), 32'(ev(1,0,0,1,1,0,0,0,0,0,1,0)));
    run(F_NOP, 0, 0, 0);
    check("nop_cyc", cyc, 2);
    check("nop_ret", 32'(instret), 1);
    run(F_LW, 2, 2, 0);
    check("lw_cyc", cyc, 9);
    check("lw_exec", 32'(exe_v), 32'(ev(0,0,0,0,0,0,0,0,0,1,2,0)));
    check("lw_mem", 32'(mem_v), 32'(ev(1,0,1,0,0,0,0,0,0,0,0,0)));
    check("lw_wb", 32'(wb_v), 32'(ev(0,0,0,0,0,0,1,0,1,0,0,0)));
    check("lw_ret", 32'(instret), 2);
    run(F_BEQ, 0, 0, 1);
    check("beq_t_cyc", cyc, 3);
    check("beq_t_exec", 32'(exe_v), 32'(ev(0,0,0,0,1,1,0,0,0,1,0,0)));
    run(F_BEQ, 0, 0, 0);
    check("beq_nt_exec", 32'(exe_v), 32'(ev(0,0,0,0,0,1,0,0,0,1,0,0)));
    run(F_BNE, 0, 0, 0);
    check("bne_t_cyc", cyc, 3);
    check("bne_t_exec", 32'(exe_v), 32'(ev(0,0,0,0,1,1,0,0,0,1,0,0)));
    run(F_BNE, 0, 0, 1);
    check("bne_nt_exec", 32'(exe_v), 32'(ev(0,0,0,0,0,1,0,0,0,1,0,0)));
    check("br_ret", 32'(instret), 6);
    run(F_JALR | F_RT, 0, 0, 0);
    check("jalr_cyc", cyc, 2);
    check("jalr_dec", 32'(dec_v), 32'(ev(0,0,0,0,1,3,1,1,2,0,3,0)));
    check("jalr_ret", 32'(instret), 7);
    run(12'h000, 0, 0, 0);
    check("ill_cyc", cyc, 2);
    check("ill_pulse", ilc, 1);
    check("ill_dec", 32'(dec_v), 32'(ev(0,0,0,0,0,0,0,0,0,0,3,1)));
    check("ill_ret", 32'(instret), 7);
    run(F_RT, 0, 0, 0);
    check("rt_cyc", cyc, 4);
    check("rt_exec", 32'(exe_v), 32'(ev(0,0,0,0,0,0,0,0,0,1,0,0)));
    check("rt_wb", 32'(wb_v), 32'(ev(0,0,0,0,0,0,1,1,0,0,0,0)));
    run(F_IT, 0, 0, 0);
    check("it_exec", 32'(exe_v), 32'(ev(0,0,0,0,0,0,0,0,0,1,2,0)));
    check("it_wb", 32'(wb_v), 32'(ev(0,0,0,0,0,0,1,0,0,0,0,0)));
    run(F_SH | F_RT, 0, 0, 0);
    check("sh_exec", 32'(exe_v), 32'(ev(0,0,0,0,0,0,0,0,0,2,0,0)));
    check("sh_wb", 32'(wb_v), 32'(ev(0,0,0,0,0,0,1,1,0,0,0,0)));
    run(F_SW, 0, 0, 0);
    check("sw_cyc", cyc, 4);
    check("sw_mem", 32'(mem_v), 32'(ev(1,1,1,0,0,0,0,0,0,0,0,0)));
    run(F_JAL, 0, 0, 0);
    check("jal_dec", 32'(dec_v), 32'(ev(0,0,0,0,1,2,1,2,2,0,3,0)));
    run(F_J, 0, 0, 0);
    check("j_dec", 32'(dec_v), 32'(ev(0,0,0,0,1,2,0,0,0,0,3,0)));
    check("mix_ret", 32'(instret), 13);
    flags = F_SW;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("sw_wait_state", 32'(state), 4);
    check("sw_wait_req", 32'({mem_req, mem_we}), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'({mem_req, mem_we}), 0);
    check("arst_state", 32'(state), 0);
    check("arst_ret", 32'(instret), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check("refetch", 32'(o), 32'(ev(1,0,0,1,1,0,0,0,0,0,1,0)));
    run(F_JR, 0, 0, 0);
    check("jr_dec", 32'(dec_v), 32'(ev(0,0,0,0,1,3,0,0,0,0,3,0)));
    for (int i = 0; i < 14; i++) run(F_NOP, 0, 0, 0);
    check("pre_wrap", 32'(instret), 15);
    run(F_NOP, 0, 0, 0);
    check("wrap", 32'(instret), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
